// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and the
// instruction memory (slave).
interface fetch_stage_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata;
   logic        imemReady;

   modport master (output imemReq, output imemAddr, input imemRdata, input imemReady);
   modport slave  (input imemReq, input imemAddr, output imemRdata, output imemReady);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stallF,
   input  logic               stallD,
   input  logic               flushD,
   input  logic               pcSrcD,
   input  logic        [31:0] pcBranchD,
   fetch_stage_if.master      imem,
   output logic        [31:0] instrD,
   output logic        [31:0] pcPlus4D,
   output logic               validD,
   output logic        [31:0] fetchCount,
   output logic        [31:0] bubbleCount
);

   logic [31:0] pc_p0;
   logic [31:0] pcplus4_p0;
   logic [31:0] target_p0;
   logic        accept_p0;
   logic        bubble_p0;

   logic [31:0] instr_p1;
   logic [31:0] pcplus4_p1;
   logic        vld_p1;

   function automatic logic [31:0] add4(input logic [31:0] a);
      return a + 32'd4;
   endfunction

   assign pcplus4_p0    = add4(pc_p0);
   assign target_p0     = pcBranchD & 32'hFFFF_FFFC;
   assign accept_p0     = imem.imemReady & ~stallF & ~stallD & ~pcSrcD;
   // flush wins over stall; otherwise an unaccepted cycle drops a bubble in
   assign bubble_p0     = flushD | (~stallD & ~accept_p0);

   assign imem.imemReq  = ~reset;
   assign imem.imemAddr = pc_p0;

   // ---- IF: program counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_p0 <= RESET_PC;
      end else if (!stallF) begin
         if (pcSrcD)
            pc_p0 <= target_p0;
         else if (imem.imemReady)
            pc_p0 <= pcplus4_p0;
      end
   end

   // ---- IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_p1   <= 32'h0;
         pcplus4_p1 <= 32'h0;
         vld_p1     <= 1'b0;
      end else if (bubble_p0) begin
         instr_p1   <= 32'h0;
         pcplus4_p1 <= 32'h0;
         vld_p1     <= 1'b0;
      end else if (accept_p0) begin
         instr_p1   <= imem.imemRdata;
         pcplus4_p1 <= pcplus4_p0;
         vld_p1     <= 1'b1;
      end
   end

   assign instrD   = instr_p1;
   assign pcPlus4D = pcplus4_p1;
   assign validD   = vld_p1;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_p1;
   logic [31:0] bubble_cnt_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_p1  <= 32'h0;
         bubble_cnt_p1 <= 32'h0;
      end else begin
         if (accept_p0 && !flushD)
            fetch_cnt_p1 <= fetch_cnt_p1 + 32'd1;
         if (bubble_p0)
            bubble_cnt_p1 <= bubble_cnt_p1 + 32'd1;
      end
   end

   assign fetchCount  = fetch_cnt_p1;
   assign bubbleCount = bubble_cnt_p1;
`else
   assign fetchCount  = 32'h0;
   assign bubbleCount = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (RESET_PC = 0x40).
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        stallF, stallD, flushD, pcSrcD;
   logic [31:0] pcBranchD;
   logic [31:0] instrD, pcPlus4D, fetchCount, bubbleCount;
   logic        validD;
   int          vectors = 0;
   int          miscompares = 0;

   fetch_stage_if ifc ();

   fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
      .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .pcSrcD(pcSrcD), .pcBranchD(pcBranchD), .imem(ifc.master),
      .instrD(instrD), .pcPlus4D(pcPlus4D), .validD(validD),
      .fetchCount(fetchCount), .bubbleCount(bubbleCount)
   );

   always #5 clk = ~clk;

   // Memory image: 0x40 holds add $1,$2,$3; other words are {~a[15:0], a[15:0]}.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h0043_0820;
      return {~a[15:0], a[15:0]};
   endfunction

   assign ifc.imemRdata = ifc.imemReady ? mem_word(ifc.imemAddr) : 32'hDEAD_BEEF;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stallF = 0; stallD = 0; flushD = 0; pcSrcD = 0;
      pcBranchD = 32'h0; ifc.imemReady = 1'b1;
      step(); step();
      vectors++;
      if ({ifc.imemReq, ifc.imemAddr, instrD, pcPlus4D, validD} !== {1'b0, 32'h40, 32'h0, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got req=%b addr=%h instr=%h pc4=%h v=%b, want 0 00000040 0 0 0",
                  ifc.imemReq, ifc.imemAddr, instrD, pcPlus4D, validD);
      end
      vectors++;
      if ({fetchCount, bubbleCount} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_counters: got %h/%h, want 0/0", fetchCount, bubbleCount);
      end
   endtask

   task automatic test_first_fetch();
      reset = 1'b0;
      #1;
      vectors++;
      if ({ifc.imemReq, ifc.imemAddr} !== {1'b1, 32'h40}) begin
         miscompares++;
         $display("FAIL req_after_reset: got req=%b addr=%h, want 1 00000040", ifc.imemReq, ifc.imemAddr);
      end
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'h0043_0820, 32'h44, 1'b1, 32'h44}) begin
         miscompares++;
         $display("FAIL first_fetch: got %h %h %b addr=%h, want 00430820 00000044 1 00000044",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
   endtask

   task automatic test_back_to_back();
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'hFFBB_0044, 32'h48, 1'b1, 32'h48}) begin
         miscompares++;
         $display("FAIL back_to_back: got %h %h %b addr=%h, want ffbb0044 00000048 1 00000048",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      vectors++;
      if (fetchCount !== (PERF ? 32'd2 : 32'd0)) begin
         miscompares++;
         $display("FAIL fetch_count_b2b: got %0d, want %0d", fetchCount, PERF ? 2 : 0);
      end
   endtask

   task automatic test_mem_wait();
      ifc.imemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'h0, 32'h0, 1'b0, 32'h48}) begin
            miscompares++;
            $display("FAIL mem_wait_%0d: got %h %h %b addr=%h, want 0 0 0 00000048",
                     i, instrD, pcPlus4D, validD, ifc.imemAddr);
         end
      end
      vectors++;
      if (bubbleCount !== (PERF ? 32'd3 : 32'd0)) begin
         miscompares++;
         $display("FAIL bubble_count_wait: got %0d, want %0d", bubbleCount, PERF ? 3 : 0);
      end
      ifc.imemReady = 1'b1;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'hFFB7_0048, 32'h4C, 1'b1, 32'h4C}) begin
         miscompares++;
         $display("FAIL wait_resume: got %h %h %b addr=%h, want ffb70048 0000004c 1 0000004c",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      step();
   endtask

   task automatic test_branch();
      vectors++;
      if (ifc.imemAddr !== 32'h50) begin
         miscompares++;
         $display("FAIL branch_setup: got addr=%h, want 00000050", ifc.imemAddr);
      end
      pcSrcD = 1'b1; pcBranchD = 32'h0000_0103;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'h0, 32'h0, 1'b0, 32'h100}) begin
         miscompares++;
         $display("FAIL branch_redirect: got %h %h %b addr=%h, want 0 0 0 00000100",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      pcSrcD = 1'b0;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'hFEFF_0100, 32'h104, 1'b1, 32'h104}) begin
         miscompares++;
         $display("FAIL branch_target: got %h %h %b addr=%h, want feff0100 00000104 1 00000104",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      vectors++;
      if ({fetchCount, bubbleCount} !== (PERF ? {32'd5, 32'd4} : 64'h0)) begin
         miscompares++;
         $display("FAIL counters_branch: got %0d/%0d, want %0d/%0d",
                  fetchCount, bubbleCount, PERF ? 5 : 0, PERF ? 4 : 0);
      end
   endtask

   task automatic test_stall_flush();
      stallF = 1'b1; stallD = 1'b1;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'hFEFF_0100, 32'h104, 1'b1, 32'h104}) begin
         miscompares++;
         $display("FAIL stall_hold: got %h %h %b addr=%h, want feff0100 00000104 1 00000104",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      flushD = 1'b1;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'h0, 32'h0, 1'b0, 32'h104}) begin
         miscompares++;
         $display("FAIL stall_flush: got %h %h %b addr=%h, want 0 0 0 00000104",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'hFEFB_0104, 32'h108, 1'b1, 32'h108}) begin
         miscompares++;
         $display("FAIL stall_release: got %h %h %b addr=%h, want fefb0104 00000108 1 00000108",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
   endtask

   task automatic test_wrap();
      pcSrcD = 1'b1; pcBranchD = 32'hFFFF_FFFF;
      step();
      vectors++;
      if ({validD, ifc.imemAddr} !== {1'b0, 32'hFFFF_FFFC}) begin
         miscompares++;
         $display("FAIL wrap_redirect: got v=%b addr=%h, want 0 fffffffc", validD, ifc.imemAddr);
      end
      pcSrcD = 1'b0;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'h0003_FFFC, 32'h0, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL wrap_fetch: got %h %h %b addr=%h, want 0003fffc 0 1 0",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
   endtask

   task automatic test_stallf_beats_branch();
      stallF = 1'b1; pcSrcD = 1'b1; pcBranchD = 32'h0000_0200;
      step();
      vectors++;
      if ({validD, ifc.imemAddr} !== {1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL stallf_branch: got v=%b addr=%h, want 0 00000000", validD, ifc.imemAddr);
      end
      stallF = 1'b0; pcSrcD = 1'b0;
      step();
      vectors++;
      if ({instrD, pcPlus4D, validD, ifc.imemAddr} !== {32'hFFFF_0000, 32'h4, 1'b1, 32'h4}) begin
         miscompares++;
         $display("FAIL after_dropped_branch: got %h %h %b addr=%h, want ffff0000 00000004 1 00000004",
                  instrD, pcPlus4D, validD, ifc.imemAddr);
      end
      vectors++;
      if ({fetchCount, bubbleCount} !== (PERF ? {32'd8, 32'd7} : 64'h0)) begin
         miscompares++;
         $display("FAIL counters_late: got %0d/%0d, want %0d/%0d",
                  fetchCount, bubbleCount, PERF ? 8 : 0, PERF ? 7 : 0);
      end
   endtask

   task automatic test_async_reset();
      #3;
      reset = 1'b1;
      #1;
      vectors++;
      if ({ifc.imemReq, ifc.imemAddr, instrD, pcPlus4D, validD, fetchCount, bubbleCount} !==
          {1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL async_reset: got req=%b addr=%h %h %h %b cnt=%0d/%0d, want 0 00000040 0 0 0 0/0",
                  ifc.imemReq, ifc.imemAddr, instrD, pcPlus4D, validD, fetchCount, bubbleCount);
      end
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_first_fetch();
      test_back_to_back();
      test_mem_wait();
      test_branch();
      test_stall_flush();
      test_wrap();
      test_stallf_beats_branch();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
